// File: rtl/convertidor_bcd_binario_param.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift step per cycle.
// Flags bad input digits and results that do not fit in ANCHO_BIN bits.
module convertidor_bcd_binario_param #(
  parameter int unsigned DIGITOS   = 5,
  parameter int unsigned ANCHO_BIN = 16
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [4*DIGITOS-1:0]   entrada_bcd,
  output logic [ANCHO_BIN-1:0]   resultado_bin,
  output logic                   terminado,
  output logic                   ocupado,
  output logic                   error_digito,
  output logic                   desbordamiento
);

  localparam int unsigned ANCHO_BCD = 4 * DIGITOS;
  localparam int unsigned ANCHO_REG = ANCHO_BCD + ANCHO_BIN;
  localparam int unsigned ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  typedef enum logic [1:0] {REPOSO, CONVERTIR, FIN} estado_t;

  estado_t                estado_q, estado_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [ANCHO_BCD-1:0]   bcd_q, bcd_d;
  logic [ANCHO_BIN-1:0]   bin_q, bin_d;
  logic [ANCHO_BIN-1:0]   resultado_q, resultado_d;
  logic                   terminado_q, terminado_d;
  logic                   ocupado_q, ocupado_d;
  logic                   error_q, error_d;
  logic                   desb_q, desb_d;

  logic [ANCHO_REG-1:0]   reg_desp;
  logic [ANCHO_BCD-1:0]   bcd_desp, bcd_corr;
  logic [ANCHO_BIN-1:0]   bin_desp;
  logic                   digito_invalido;

  // One datapath step: shift the whole register right, then correct each digit >= 8.
  always_comb begin
    reg_desp = {bcd_q, bin_q} >> 1;
    bcd_desp = reg_desp[ANCHO_REG-1:ANCHO_BIN];
    bin_desp = reg_desp[ANCHO_BIN-1:0];
    bcd_corr = bcd_desp;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (bcd_desp[4*i +: 4] >= 4'd8) begin
        bcd_corr[4*i +: 4] = bcd_desp[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (entrada_bcd[4*i +: 4] > 4'd9) begin
        digito_invalido = 1'b1;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    resultado_d = resultado_q;
    error_d     = error_q;
    desb_d      = desb_q;

    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          if (digito_invalido) begin
            resultado_d = '0;
            error_d     = 1'b1;
            desb_d      = 1'b0;
            estado_d    = FIN;
          end else begin
            bcd_d    = entrada_bcd;
            bin_d    = '0;
            cnt_d    = ANCHO_CNT'(ANCHO_BIN);
            error_d  = 1'b0;
            desb_d   = 1'b0;
            estado_d = CONVERTIR;
          end
        end
      end
      CONVERTIR: begin
        bcd_d = bcd_corr;
        bin_d = bin_desp;
        cnt_d = cnt_q - ANCHO_CNT'(1);
        if (cnt_q == ANCHO_CNT'(1)) begin
          resultado_d = bin_desp;
          desb_d      = |bcd_corr;
          estado_d    = FIN;
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase

    terminado_d = (estado_d == FIN);
    ocupado_d   = (estado_d != REPOSO);
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q    <= REPOSO;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      resultado_q <= '0;
      terminado_q <= 1'b0;
      ocupado_q   <= 1'b0;
      error_q     <= 1'b0;
      desb_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      resultado_q <= resultado_d;
      terminado_q <= terminado_d;
      ocupado_q   <= ocupado_d;
      error_q     <= error_d;
      desb_q      <= desb_d;
    end
  end

  assign resultado_bin  = resultado_q;
  assign terminado      = terminado_q;
  assign ocupado        = ocupado_q;
  assign error_digito   = error_q;
  assign desbordamiento = desb_q;

endmodule

// File: tb/tb_convertidor_bcd_binario_param.sv
// Directed bench for convertidor_bcd_binario_param: vector table on a 5-digit/16-bit
// instance plus smaller configurations and multi-cycle corner sequences.
module tb_convertidor_bcd_binario_param;

  logic reloj = 1'b0;
  logic reset;
  always #5 reloj = ~reloj;

  logic        inicio0, term0, ocu0, err0, desb0;
  logic [19:0] bcd0;
  logic [15:0] res0;
  logic        inicio1, term1, ocu1, err1, desb1;
  logic [15:0] bcd1;
  logic [13:0] res1;
  logic        inicio2, term2, ocu2, err2, desb2;
  logic [11:0] bcd2;
  logic [9:0]  res2;

  convertidor_bcd_binario_param #(.DIGITOS(5), .ANCHO_BIN(16)) dut0 (
    .reloj(reloj), .reset(reset), .inicio(inicio0), .entrada_bcd(bcd0),
    .resultado_bin(res0), .terminado(term0), .ocupado(ocu0),
    .error_digito(err0), .desbordamiento(desb0));

  convertidor_bcd_binario_param #(.DIGITOS(4), .ANCHO_BIN(14)) dut1 (
    .reloj(reloj), .reset(reset), .inicio(inicio1), .entrada_bcd(bcd1),
    .resultado_bin(res1), .terminado(term1), .ocupado(ocu1),
    .error_digito(err1), .desbordamiento(desb1));

  convertidor_bcd_binario_param #(.DIGITOS(3), .ANCHO_BIN(10)) dut2 (
    .reloj(reloj), .reset(reset), .inicio(inicio2), .entrada_bcd(bcd2),
    .resultado_bin(res2), .terminado(term2), .ocupado(ocu2),
    .error_digito(err2), .desbordamiento(desb2));

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] res;
    logic        err;
    logic        desb;
    int          lat;
  } vec_t;

  vec_t tabla[9];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, actual, esperado);
    end
  endtask

  // Start dut0 and wait (bounded) for terminado; lat counts edges after the accepting edge.
  task automatic arrancar0(input logic [19:0] v, input logic err_esp, output int lat);
    bcd0    = v;
    inicio0 = 1'b1;
    @(posedge reloj); #1;
    inicio0 = 1'b0;
    chk("ocupado_tras_E0", 32'(ocu0), 32'd1);
    chk("error_tras_E0", 32'(err0), 32'(err_esp));
    lat = 0;
    while (!term0 && lat < 40) begin
      @(posedge reloj); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, pulsos, t0, t1, t2;
    logic [15:0] r;

    tabla[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0, 16};
    tabla[1] = '{20'h99999, 16'h869F, 1'b0, 1'b1, 16};
    tabla[2] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0, 16};
    tabla[3] = '{20'h00000, 16'h0000, 1'b0, 1'b0, 16};
    tabla[4] = '{20'h1A345, 16'h0000, 1'b1, 1'b0, 0};
    tabla[5] = '{20'h00042, 16'h002A, 1'b0, 1'b0, 16};
    tabla[6] = '{20'h65536, 16'h0000, 1'b0, 1'b1, 16};
    tabla[7] = '{20'h0000F, 16'h0000, 1'b1, 1'b0, 0};
    tabla[8] = '{20'h09999, 16'h270F, 1'b0, 1'b0, 16};

    reset = 1'b1;
    inicio0 = 1'b0; inicio1 = 1'b0; inicio2 = 1'b0;
    bcd0 = '0; bcd1 = '0; bcd2 = '0;
    repeat (3) @(posedge reloj);
    #1;
    chk("reset_resultado", 32'(res0), 32'd0);
    chk("reset_terminado", 32'(term0), 32'd0);
    chk("reset_ocupado", 32'(ocu0), 32'd0);
    chk("reset_error", 32'(err0), 32'd0);
    chk("reset_desb", 32'(desb0), 32'd0);
    reset = 1'b0;
    @(posedge reloj); #1;

    for (int i = 0; i < 9; i++) begin
      arrancar0(tabla[i].bcd, tabla[i].err, lat);
      chk($sformatf("latencia[%0d]", i), 32'(lat), 32'(tabla[i].lat));
      chk($sformatf("resultado[%0d]", i), 32'(res0), 32'(tabla[i].res));
      chk($sformatf("error[%0d]", i), 32'(err0), 32'(tabla[i].err));
      chk($sformatf("desb[%0d]", i), 32'(desb0), 32'(tabla[i].desb));
      @(posedge reloj); #1;
      chk($sformatf("terminado_un_ciclo[%0d]", i), 32'(term0), 32'd0);
      chk($sformatf("ocupado_cae[%0d]", i), 32'(ocu0), 32'd0);
    end

    // Smaller configurations.
    bcd1 = 16'h9999; inicio1 = 1'b1;
    @(posedge reloj); #1;
    inicio1 = 1'b0;
    lat = 0;
    while (!term1 && lat < 40) begin @(posedge reloj); #1; lat++; end
    chk("d4_latencia", 32'(lat), 32'd14);
    chk("d4_resultado", 32'(res1), 32'h270F);
    chk("d4_desb", 32'(desb1), 32'd0);
    chk("d4_error", 32'(err1), 32'd0);

    bcd2 = 12'h999; inicio2 = 1'b1;
    @(posedge reloj); #1;
    inicio2 = 1'b0;
    lat = 0;
    while (!term2 && lat < 40) begin @(posedge reloj); #1; lat++; end
    chk("d3_latencia", 32'(lat), 32'd10);
    chk("d3_resultado", 32'(res2), 32'h3E7);
    chk("d3_desb", 32'(desb2), 32'd0);
    @(posedge reloj); #1;

    // Input change and extra start request during a conversion.
    bcd0 = 20'h12345; inicio0 = 1'b1;
    @(posedge reloj); #1;
    inicio0 = 1'b0;
    pulsos = 0; r = '0;
    for (int n = 0; n < 30; n++) begin
      if (n == 4) begin
        bcd0 = 20'h54321;
        inicio0 = 1'b1;
      end else begin
        inicio0 = 1'b0;
      end
      if (term0) begin
        pulsos++;
        r = res0;
      end
      @(posedge reloj); #1;
    end
    chk("ignora_inicio_pulsos", 32'(pulsos), 32'd1);
    chk("ignora_inicio_resultado", 32'(r), 32'h3039);

    // inicio held high: one conversion every ANCHO_BIN+2 cycles.
    bcd0 = 20'h00042; inicio0 = 1'b1;
    pulsos = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge reloj); #1;
      if (term0) begin
        if (pulsos == 0) t0 = k;
        if (pulsos == 1) t1 = k;
        if (pulsos == 2) t2 = k;
        pulsos++;
      end
    end
    inicio0 = 1'b0;
    chk("continuo_pulsos", 32'(pulsos), 32'd3);
    chk("continuo_periodo1", 32'(t1 - t0), 32'd18);
    chk("continuo_periodo2", 32'(t2 - t1), 32'd18);
    repeat (25) @(posedge reloj);
    #1;

    // Reset mid-conversion aborts with outputs cleared and no completion.
    bcd0 = 20'h12345; inicio0 = 1'b1;
    @(posedge reloj); #1;
    inicio0 = 1'b0;
    repeat (6) @(posedge reloj);
    #1;
    reset = 1'b1;
    @(posedge reloj); #1;
    chk("abort_resultado", 32'(res0), 32'd0);
    chk("abort_terminado", 32'(term0), 32'd0);
    chk("abort_ocupado", 32'(ocu0), 32'd0);
    chk("abort_error", 32'(err0), 32'd0);
    chk("abort_desb", 32'(desb0), 32'd0);
    reset = 1'b0;
    pulsos = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge reloj); #1;
      if (term0) pulsos++;
    end
    chk("abort_sin_terminado", 32'(pulsos), 32'd0);
    arrancar0(20'h00042, 1'b0, lat);
    chk("reinicio_latencia", 32'(lat), 32'd16);
    chk("reinicio_resultado", 32'(res0), 32'h002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/convertidor_bcd_binario_param.md
# convertidor_bcd_binario_param

Parametrised sequential BCD-to-binary converter using the reverse double-dabble algorithm: shift right one bit per cycle, then subtract 3 from any BCD digit ≥ 8. It generalises the fixed 5-digit/16-bit converter to any digit count and result width. It adds input-digit validation, overflow detection and a busy indication. It sits between the keypad/BCD entry path and the binary ALU of the calculator.

## Interface
- DIGITOS, 5, number of BCD digits at the input (≥ 1)
- ANCHO_BIN, 16, result width in bits; also the number of conversion steps (≥ 4)

- reloj  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- inicio  input  1  start request; sampled only in REPOSO
- entrada_bcd  input  4*DIGITOS  packed BCD operand; digit 0 is in bits [3:0]
- resultado_bin  output  ANCHO_BIN  binary result; holds until the next accepted start
- terminado  output  1  one-cycle completion pulse
- ocupado  output  1  high whenever the state is not REPOSO
- error_digito  output  1  some input digit was > 9; valid from the terminado pulse until the next accepted start
- desbordamiento  output  1  value ≥ 2^ANCHO_BIN; valid like error_digito

## Operation
- Working register: {bcd[4*DIGITOS-1:0], bin[ANCHO_BIN-1:0]}; step counter width clog2(ANCHO_BIN+1).
- FSM states: REPOSO, CONVERTIR, FIN.
- REPOSO, inicio=1, all digits ≤ 9:
  - capture entrada_bcd into bcd; clear bin
  - counter ← ANCHO_BIN; clear error_digito and desbordamiento
  - go to CONVERTIR
- REPOSO, inicio=1, any digit > 9:
  - resultado_bin ← 0; error_digito ← 1; desbordamiento ← 0
  - go directly to FIN; no conversion steps are executed
- CONVERTIR, each cycle:
  - shift the whole register right by 1; bcd MSB ← 0
  - for each digit of the shifted bcd: if ≥ 8, subtract 3 (4-bit, per digit, all digits in parallel)
  - decrement counter
  - when the counter reaches 0: resultado_bin ← new bin; desbordamiento ← (new bcd ≠ 0); go to FIN
- FIN: terminado=1 for this cycle only; go to REPOSO unconditionally. inicio is ignored in FIN.
- Result arithmetic:
  - resultado_bin = decimal value mod 2^ANCHO_BIN
  - desbordamiento=1 exactly when the value ≥ 2^ANCHO_BIN; the truncated result is still reported
- Input capture:
  - entrada_bcd is captured once at the accepting edge
  - later changes to entrada_bcd have no effect on the running conversion
  - inicio while ocupado=1 is ignored, not queued
- Reset:
  - state REPOSO, counter 0, working register 0
  - resultado_bin 0, terminado 0, ocupado 0, error_digito 0, desbordamiento 0
  - reset has priority over everything; reset mid-conversion aborts it, with no terminado pulse and outputs cleared

## Timing
- Edge E0: inicio accepted in REPOSO; ocupado=1 from the cycle after E0.
- Valid input:
  - ANCHO_BIN steps on edges E1..E(ANCHO_BIN)
  - terminado, resultado_bin and flags valid in the cycle after edge E0+ANCHO_BIN
  - ocupado drops after edge E0+ANCHO_BIN+1
- Invalid digit: terminado in the cycle after E0, with error_digito=1; ocupado drops after E0+1.
- inicio held high permanently: a new start is accepted at E0+ANCHO_BIN+2. Throughput is one conversion per ANCHO_BIN+2 cycles.
- terminado is never high for two consecutive cycles.

## Test plan
- DIGITOS=5, ANCHO_BIN=16, entrada_bcd=0x12345 → terminado in the cycle after E0+16; resultado_bin=0x3039; error_digito=0; desbordamiento=0.
- Same config, 0x99999 → resultado_bin=0x869F (99999 mod 65536); desbordamiento=1. Then 0x65535 → 0xFFFF with desbordamiento=0. Then 0x00000 → 0x0000.
- Same config, 0x1A345 → terminado in the cycle after E0; error_digito=1; resultado_bin=0. A following valid 0x00042 clears error_digito at its start and returns 0x002A.
- DIGITOS=4, ANCHO_BIN=14, 0x9999 → 0x270F with no overflow. DIGITOS=3, ANCHO_BIN=10, 0x999 → 0x3E7.
- 0x12345 started; entrada_bcd changed to 0x54321 and inicio pulsed at E0+5 → result still 0x3039, and exactly one terminado pulse.
- inicio held high → terminado pulses exactly every 18 cycles (ANCHO_BIN=16). Reset asserted at E0+7 → all outputs 0 next cycle and no terminado; a restart afterwards completes correctly.
